// File: rtl/ddram_arb2.sv
// ddram_arb2: two-client round-robin arbiter onto a single 64-bit DDRAM command port.
// Each client issues 16-bit single-word reads and writes through toggle req/ack pairs.
// One command is in flight at a time. All command outputs are registered.
module ddram_arb2 #(
  parameter logic [31:0] RAMBASE = 32'h3000_0000,
  parameter int unsigned RAMSIZE = 27
) (
  input  logic        DDRAM_CLK,
  input  logic        reset_n,

  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [29:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,

  input  logic [29:0] c0_wraddr,
  input  logic [29:0] c0_rdaddr,
  input  logic [15:0] c0_din,
  input  logic        c0_we_req,
  output logic        c0_we_ack,
  input  logic        c0_rd_req,
  output logic        c0_rd_ack,
  output logic [15:0] c0_dout,

  input  logic [29:0] c1_wraddr,
  input  logic [29:0] c1_rdaddr,
  input  logic [15:0] c1_din,
  input  logic        c1_we_req,
  output logic        c1_we_ack,
  input  logic        c1_rd_req,
  output logic        c1_rd_ack,
  output logic [15:0] c1_dout
);

  // Client address bits inside the window; the rest come from RAMBASE.
  localparam logic [28:0] AddrMask = 29'((64'd1 << (RAMSIZE + 1)) - 64'd1);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StRdWait} state_e;

  state_e             state_q;
  logic               last_q;     // client granted most recently
  logic               cid_q;      // client owning the in-flight command
  logic               req_q;      // req level sampled at grant; ack moves to this
  logic [1:0]         sel_q;      // 16-bit lane within the 64-bit word
  logic               we_q;
  logic               rd_q;
  logic [29:0]        addr_q;
  logic [63:0]        din_q;
  logic [7:0]         be_q;
  logic [1:0]         we_ack_q;
  logic [1:0]         rd_ack_q;
  logic [1:0][15:0]   dout_q;

  // Per-client views so the grant path can index by client id.
  logic [1:0][29:0]   wraddr;
  logic [1:0][29:0]   rdaddr;
  logic [1:0][15:0]   din;
  logic [1:0]         we_req;
  logic [1:0]         rd_req;

  assign wraddr = {c1_wraddr, c0_wraddr};
  assign rdaddr = {c1_rdaddr, c0_rdaddr};
  assign din    = {c1_din, c0_din};
  assign we_req = {c1_we_req, c0_we_req};
  assign rd_req = {c1_rd_req, c0_rd_req};

  logic [1:0]  we_pend;
  logic [1:0]  rd_pend;
  logic [1:0]  cand;
  logic        gnt_id;
  logic        gnt_is_wr;
  logic [29:0] gnt_addr;
  logic [15:0] gnt_din;
  logic        gnt_req;
  logic [28:0] gnt_full;

  // Candidate set, round-robin pick, and the granted client's command fields.
  always_comb begin
    we_pend   = we_req ^ we_ack_q;
    rd_pend   = rd_req ^ rd_ack_q;
    cand      = we_pend | rd_pend;
    gnt_id    = 1'b0;
    if (cand == 2'b11) begin
      gnt_id = ~last_q;
    end else if (cand == 2'b10) begin
      gnt_id = 1'b1;
    end
    gnt_is_wr = we_pend[gnt_id];
    gnt_addr  = gnt_is_wr ? wraddr[gnt_id] : rdaddr[gnt_id];
    gnt_din   = din[gnt_id];
    gnt_req   = gnt_is_wr ? we_req[gnt_id] : rd_req[gnt_id];
    gnt_full  = (RAMBASE[28:0] & ~AddrMask) | (gnt_addr[28:0] & AddrMask);
  end

  // Bits with no role: byte-select bit 0, bit 29, and the sub-word part of the full address.
  logic unused_bits;
  assign unused_bits = ^{gnt_addr[29], gnt_addr[0], gnt_full[2:0]};

  // Command FSM with registered command outputs, acks and read data.
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cid_q    <= 1'b0;
      req_q    <= 1'b0;
      sel_q    <= 2'd0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      be_q     <= '0;
      we_ack_q <= '0;
      rd_ack_q <= '0;
      dout_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!DDRAM_BUSY && (cand != 2'b00)) begin
            cid_q  <= gnt_id;
            last_q <= gnt_id;
            req_q  <= gnt_req;
            sel_q  <= gnt_addr[2:1];
            addr_q <= {4'b0000, gnt_full[28:3]};
            if (gnt_is_wr) begin
              we_q    <= 1'b1;
              din_q   <= {4{gnt_din}};
              be_q    <= 8'd3 << {gnt_addr[2:1], 1'b0};
              state_q <= StWr;
            end else begin
              rd_q    <= 1'b1;
              be_q    <= 8'hFF;
              state_q <= StRd;
            end
          end
        end
        StWr: begin
          if (!DDRAM_BUSY) begin
            we_ack_q[cid_q] <= req_q;
            we_q            <= 1'b0;
            state_q         <= StIdle;
          end
        end
        StRd: begin
          if (!DDRAM_BUSY) begin
            rd_q    <= 1'b0;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          // Read data is taken regardless of BUSY.
          if (DDRAM_DOUT_READY) begin
            dout_q[cid_q]   <= DDRAM_DOUT[{sel_q, 4'b0000} +: 16];
            rd_ack_q[cid_q] <= req_q;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_RD       = rd_q;

  assign c0_we_ack = we_ack_q[0];
  assign c1_we_ack = we_ack_q[1];
  assign c0_rd_ack = rd_ack_q[0];
  assign c1_rd_ack = rd_ack_q[1];
  assign c0_dout   = dout_q[0];
  assign c1_dout   = dout_q[1];

endmodule

// File: doc/ddram_arb2.md
# ddram_arb2

Two-client arbiter for the shared HPS DDRAM port. It accepts independent 16-bit single-word read and write requests from two clients, each using the toggle req/ack handshake. Requests are serialized onto one 64-bit DDRAM command interface with round-robin fairness. It sits between the core's memory clients (e.g. chip-RAM and fast-RAM paths) and the top-level DDRAM_* bus.

## Interface
- RAMBASE, 'h30000000: byte base of the window; bits [28:RAMSIZE+1] form the upper DDRAM_ADDR bits.
- RAMSIZE, 27: window is 2^(RAMSIZE+1) bytes; client address bits above RAMSIZE are ignored.
- DDRAM_CLK  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DDRAM_BUSY  in  1  high: the DDRAM port holds the command and the block stalls.
- DDRAM_BURSTCNT  out  8  always 1 while a command is asserted.
- DDRAM_ADDR  out  30  {RAMBASE[28:RAMSIZE+1], addr[RAMSIZE:3]}.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- DDRAM_RD / DDRAM_WE  out  1  read or write command, mutually exclusive.
- DDRAM_DIN  out  64  {4{din}}.
- DDRAM_BE  out  8  write: 8'd3 << {addr[2:1],1'b0}; read: 8'hFF.
- cN_wraddr, cN_rdaddr  in  30  byte addresses for client N (N = 0, 1); bit 0 ignored.
- cN_din  in  16  write data, sampled at grant.
- cN_we_req / cN_we_ack  in/out  1  write toggle pair; a request is pending while req != ack.
- cN_rd_req / cN_rd_ack  in/out  1  read toggle pair.
- cN_dout  out  16  registered read data; valid from the rd_ack toggle until the next read completes.

## Operation
- States: IDLE, WR, RD, RDWAIT. State advances only on cycles with DDRAM_BUSY low, except that RDWAIT reacts to DDRAM_DOUT_READY regardless of BUSY.
- IDLE: build the candidate set, where client N is a candidate if it has a write or read pending.
  - If both clients are candidates, grant the client other than `last`.
  - If one client is a candidate, grant it.
  - Within the granted client, a write beats a read.
  - On grant:
    - Latch the client id, address and data.
    - Set `last` to the granted client.
    - Assert WE (go to WR) or RD (go to RD) that cycle.
- WR: the command is held while BUSY is high. On the first cycle with BUSY low:
  - Toggle cN_we_ack to equal cN_we_req.
  - Deassert WE.
  - Return to IDLE.
- RD: the command is held until BUSY is low. Then deassert RD and go to RDWAIT.
- RDWAIT: on DDRAM_DOUT_READY:
  - cN_dout <= DDRAM_DOUT[{addr[2:1],4'b0} +: 16].
  - Toggle cN_rd_ack.
  - Return to IDLE.
  - Other data-ready pulses outside RDWAIT are ignored.
- Acks only move to equal the sampled req. A req that toggles again while its request is in flight is not lost; it is seen in IDLE as a new pending request.
- Address and data changes by a client after grant have no effect on the in-flight command.
- The other client's ack and dout never change during a transaction.

## Timing
- Reset (async assert, sync-released use): state IDLE, `last` = 1 (client 0 wins the first tie), all acks 0, all cN_dout 0, RD/WE 0, BURSTCNT 1, DIN/BE/ADDR 0.
- Reset mid-transaction:
  - The command is dropped immediately.
  - Acks return to 0; clients are reset with the same reset_n.
- Write latency with BUSY low:
  - Cycle 0: req toggle seen, WE high.
  - Cycle 1: ack toggled, block back in IDLE.
  - Cycle 2 at the earliest: next grant.
  - Each BUSY-high cycle adds one cycle.
- Read latency: RD for 1 cycle (plus BUSY stalls), then the DDRAM response time, then ack and dout one cycle after DOUT_READY.
- Throughput: one command per 2 cycles minimum; no pipelining of outstanding reads (max 1 in flight).
- Fairness: with both clients continuously pending, grants strictly alternate 0,1,0,1.

## Test plan
- Client 0 write with c0_wraddr = 0x0000_0006, din = 0xBEEF, BUSY low:
  - Required: WE for one cycle with DDRAM_ADDR = {RAMBASE[28:28], 0x0000000}, BE = 0xC0, DIN = 0xBEEFBEEFBEEFBEEF.
  - c0_we_ack toggles on the next cycle.
- Client 1 read at 0x0000_0012, DOUT = 0x1111_2222_3333_4444, returned 5 cycles after RD:
  - Required: BE = 0xFF and c1_dout = 0x3333.
  - c1_rd_ack toggles one cycle after DOUT_READY.
- Both clients toggle write req in the same cycle after reset:
  - Required: client 0 granted first, then client 1.
  - With both then re-requesting, order is 0,1,0,1.
- Client 0 raises a write and a read in the same cycle:
  - Required: the write is issued first, the read next.
  - Client 1 pending at that time is served between them (RR).
- BUSY held high for 4 cycles while WE is asserted:
  - Required: WE, ADDR, DIN and BE are stable for all 4 cycles.
  - Ack only after BUSY falls.
  - Changes to c0_din during the stall are not reflected in DIN.
- reset_n pulsed low while in RDWAIT:
  - Required: outputs reach reset values asynchronously.
  - A late DOUT_READY after release produces no ack and no dout change.
